shift_checker: RTL and testbench

SHIFT_CHECKER -- requirements
Module: shift_checker

---
 rtl/shift_checker.sv | 102 ++++++++++
 tb/tb_shift_checker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shift_checker.sv
// Serial shifter checker: captures a shift/rotate transaction, replays it one bit
// per cycle, and compares the result against the shifter-under-check's output.
module shift_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] data_in,
    input  logic [2:0] shift_amt,
    input  logic [2:0] op_code,
    input  logic [7:0] data_out,
    output logic       chk_valid,
    output logic       chk_pass,
    output logic [7:0] expected,
    output logic [7:0] err_count,
    output logic [7:0] chk_count
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    state_t     state;
    logic [7:0] acc;
    logic [2:0] rem;
    logic [2:0] op_q;
    logic [7:0] dout_q;

    logic [7:0] acc_step;
    logic       op_legal;
    logic       pass_now;

    // One-bit step of the accumulator; illegal ops leave it untouched.
    always_comb begin
        acc_step = acc;
        case (op_q)
            OP_LSL:  acc_step = {acc[6:0], 1'b0};
            OP_LSR:  acc_step = {1'b0, acc[7:1]};
            OP_ASR:  acc_step = {acc[7], acc[7:1]};
            OP_ROL:  acc_step = {acc[6:0], acc[7]};
            OP_ROR:  acc_step = {acc[0], acc[7:1]};
            default: acc_step = acc;
        endcase
    end

    assign op_legal = (op_q <= OP_ROR);
    assign pass_now = (acc == dout_q) && op_legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            acc       <= 8'd0;
            rem       <= 3'd0;
            op_q      <= 3'd0;
            dout_q    <= 8'd0;
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            expected  <= 8'd0;
            err_count <= 8'd0;
            chk_count <= 8'd0;
        end else begin
            chk_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= data_in;
                        rem      <= shift_amt;
                        op_q     <= op_code;
                        dout_q   <= data_out;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (rem != 3'd0) begin
                        acc <= acc_step;
                        rem <= rem - 3'd1;
                    end else begin
                        expected  <= acc;
                        chk_pass  <= pass_now;
                        chk_valid <= 1'b1;
                        chk_count <= chk_count + 8'd1;
                        if (!pass_now && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_checker.sv
// Directed bench for shift_checker: hand-computed vectors, latency, reset and
// counter saturation checks.
module tb_shift_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic [2:0] shift_amt;
    logic [2:0] op_code;
    logic [7:0] data_out;
    logic       chk_valid;
    logic       chk_pass;
    logic [7:0] expected;
    logic [7:0] err_count;
    logic [7:0] chk_count;

    int errors = 0;
    int checks = 0;

    shift_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .op_code   (op_code),
        .data_out  (data_out),
        .chk_valid (chk_valid),
        .chk_pass  (chk_pass),
        .expected  (expected),
        .err_count (err_count),
        .chk_count (chk_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one transaction, scribble on the inputs while it runs, and return
    // in the cycle chk_valid is high. Latency is measured in edges after accept.
    task automatic run(input logic [7:0] din, input logic [2:0] amt,
                       input logic [2:0] op, input logic [7:0] dout, input string tag);
        int n;
        in_valid  = 1'b1;
        data_in   = din;
        shift_amt = amt;
        op_code   = op;
        data_out  = dout;
        tick();
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_nopulse"}, {31'd0, chk_valid}, 32'd0);
        n = 0;
        while (!chk_valid && n < 20) begin
            in_valid  = 1'b1;
            data_in   = ~din;
            shift_amt = 3'd7 - amt;
            op_code   = op ^ 3'b011;
            data_out  = ~dout;
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, n, amt + 1);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; shift_amt = '0; op_code = '0; data_out = '0;
        do_reset();
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, chk_valid}, 32'd0);
        check("rst_pass", {31'd0, chk_pass}, 32'd0);
        check("rst_exp", {24'd0, expected}, 32'h00);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_cnt", {24'd0, chk_count}, 32'd0);

        // Idle with in_valid low: nothing happens
        data_in = 8'hFF; shift_amt = 3'd1;
        tick(); tick();
        check("idle_hold", {31'd0, in_ready}, 32'd1);
        check("idle_nopulse", {31'd0, chk_valid}, 32'd0);

        run(8'b10101010, 3'd3, 3'b000, 8'b01010000, "lsl");
        check("lsl_exp", {24'd0, expected}, 32'h50);
        check("lsl_pass", {31'd0, chk_pass}, 32'd1);
        check("lsl_cnt", {24'd0, chk_count}, 32'd1);

        do_reset();
        run(8'b11001100, 3'd2, 3'b001, 8'b00110011, "lsr");
        check("lsr_exp", {24'd0, expected}, 32'h33);
        check("lsr_pass", {31'd0, chk_pass}, 32'd1);
        run(8'b11110000, 3'd4, 3'b010, 8'b11111111, "asr");
        check("asr_exp", {24'd0, expected}, 32'hFF);
        check("asr_pass", {31'd0, chk_pass}, 32'd1);
        check("asr_cnt", {24'd0, chk_count}, 32'd2);
        check("asr_err", {24'd0, err_count}, 32'd0);

        run(8'b10011001, 3'd3, 3'b011, 8'b11001100, "rol");
        check("rol_exp", {24'd0, expected}, 32'hCC);
        check("rol_pass", {31'd0, chk_pass}, 32'd1);
        run(8'b01101110, 3'd2, 3'b100, 8'b10011010, "ror");
        check("ror_exp", {24'd0, expected}, 32'h9B);
        check("ror_pass", {31'd0, chk_pass}, 32'd0);
        check("ror_err", {24'd0, err_count}, 32'd1);

        run(8'h5A, 3'd0, 3'b101, 8'h5A, "ill");
        check("ill_exp", {24'd0, expected}, 32'h5A);
        check("ill_pass", {31'd0, chk_pass}, 32'd0);
        check("ill_err", {24'd0, err_count}, 32'd2);
        check("ill_cnt", {24'd0, chk_count}, 32'd5);
        tick();
        check("hold_valid", {31'd0, chk_valid}, 32'd0);
        check("hold_exp", {24'd0, expected}, 32'h5A);
        check("hold_pass", {31'd0, chk_pass}, 32'd0);

        run(8'hC3, 3'd7, 3'b011, 8'hE1, "rol7");
        check("rol7_exp", {24'd0, expected}, 32'hE1);
        check("rol7_pass", {31'd0, chk_pass}, 32'd1);

        // Reset at the third SHIFT edge abandons the transaction
        in_valid = 1'b1; data_in = 8'h81; shift_amt = 3'd7; op_code = 3'b000; data_out = 8'h80;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_valid", {31'd0, chk_valid}, 32'd0);
        check("mid_ready", {31'd0, in_ready}, 32'd1);
        check("mid_err", {24'd0, err_count}, 32'd0);
        check("mid_cnt", {24'd0, chk_count}, 32'd0);
        check("mid_exp", {24'd0, expected}, 32'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_quiet", {31'd0, chk_valid}, 32'd0);
        end

        // Saturation: every check fails
        for (int i = 0; i < 255; i++)
            run(8'h00, 3'd0, 3'b000, 8'h01, "sat");
        check("sat_err255", {24'd0, err_count}, 32'd255);
        check("sat_cnt255", {24'd0, chk_count}, 32'd255);
        run(8'h00, 3'd0, 3'b000, 8'h01, "sat_last");
        check("sat_err", {24'd0, err_count}, 32'd255);
        check("sat_cnt", {24'd0, chk_count}, 32'd0);
        check("sat_pass", {31'd0, chk_pass}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
